booth_mult_seq: RTL and testbench

//  Sequential signed multiplier controller. Computes a 2*WIDTH-bit signed product one 4-bit Booth window per cycle.

---
 rtl/mult_pkg.sv | 17 +
 rtl/booth4_pp.sv | 26 ++
 rtl/booth_mult_seq.sv | 89 ++++++++
 tb/tb_booth_mult_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants, FSM encoding and step-count helper for the sequential Booth multiplier.
package mult_pkg;

  localparam int CHUNK = 4;
  localparam int ACC_W = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps(input int width);
    return width / CHUNK;
  endfunction

endpackage

// File: rtl/booth4_pp.sv
// Combinational radix-16 Booth partial product: pp = digit(w) * mc, sign-extended.
module booth4_pp
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PPW   = WIDTH + CHUNK
) (
  input  logic [WIDTH-1:0] mc,
  input  logic [4:0]       w,
  output logic [PPW-1:0]   pp
);

  // (w0-w1) + 2(w1-w2) + 4(w2-w3) + 8(w3-w4) collapses to w0 + w1 + 2w2 + 4w3 - 8w4, range -8..8.
  logic signed [5:0]     digit;
  logic signed [PPW-1:0] digit_x;
  logic signed [PPW-1:0] mc_x;

  always_comb begin
    digit   = $signed({5'b0, w[0]}) + $signed({5'b0, w[1]}) + $signed({4'b0, w[2], 1'b0})
            + $signed({3'b0, w[3], 2'b0}) - $signed({2'b0, w[4], 3'b0});
    digit_x = PPW'(digit);
    mc_x    = PPW'($signed(mc));
    pp      = digit_x * mc_x;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier, one radix-16 Booth step per cycle; start/busy/done handshake.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the RUN steps and finishes in one cycle.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int STEPS = steps(WIDTH);
  localparam int AW    = WIDTH + CHUNK;   // ACC_W for the default 32-bit build
  localparam int CW    = $clog2(STEPS);

  state_t              state, nxt;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    mc, lo;
  logic [AW-1:0]       hi;
  logic                prev;
  logic [AW-1:0]       pp, s;
  logic [AW+WIDTH-1:0] sh;
  logic                accept, last, zero_op;

  booth4_pp #(.WIDTH(WIDTH), .PPW(AW)) u_pp (
    .mc (mc),
    .w  ({lo[3:0], prev}),
    .pp (pp)
  );

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(STEPS - 1));
  assign s      = hi + pp;
  assign sh     = $signed({s, lo}) >>> CHUNK;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = zero_op ? DONE : RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mc      <= '0;
      lo      <= '0;
      hi      <= '0;
      prev    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mc   <= a;
      lo   <= b;
      hi   <= '0;
      prev <= 1'b0;
      cnt  <= '0;
      if (zero_op) product <= '0;
    end else if (state == RUN) begin
      // lo shifts out consumed multiplier bits while product bits shift in from the accumulator.
      {hi, lo} <= sh;
      prev     <= lo[3];
      cnt      <= cnt + 1'b1;
      if (last) product <= sh[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector and random bench for booth_mult_seq (WIDTH=32).
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int total  = 0;
  int passed = 0;
  logic done_q = 1'b0;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      check("busy_with_done", {63'b0, busy}, 64'd1);
      check("done_pulse", {63'b0, done_q}, 64'd0);
    end
    done_q = done;
  end

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [63:0] p, output int lat);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      a = $urandom; b = $urandom;
    end while (!done && lat < 40);
    p = product;
    @(negedge clk);
    check("idle_after_done", {62'b0, busy, done}, 64'd0);
  endtask

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_ZERO_BYPASS_EN
    if (x == 32'd0 || y == 32'd0) return 1;
`endif
    return 9;
  endfunction

  vec_t        vecs[11];
  logic [63:0] p;
  int          lat;

  initial begin
    vecs[0]  = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1]  = '{-32'sd7,        32'd6,          64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[3]  = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[4]  = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
    vecs[5]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000};
    vecs[7]  = '{32'd1,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{32'h1234_5678,  32'd16,         64'h0000_0001_2345_6780};
    vecs[9]  = '{32'd0,          32'd123,        64'h0000_0000_0000_0000};
    vecs[10] = '{32'd9,          32'd9,          64'h0000_0000_0000_0051};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {busy, done, 62'b0}, 64'd0);
    check("reset_product", product, 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].p);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
    end

    // start held for 20 cycles: ops accepted only from IDLE, 10 cycles apart.
    begin
      int n_done = 0;
      int first = 0, second = 0;
      logic [63:0] p1 = '0, p2 = '0;
      @(negedge clk);
      a = 32'd2; b = 32'd2; start = 1'b1;
      for (int i = 1; i <= 26; i++) begin
        @(negedge clk);
        if (i == 3)  a = 32'd7;
        if (i == 6)  a = 32'd2;
        if (i == 20) start = 1'b0;
        if (done) begin
          n_done++;
          if (n_done == 1) begin first = i; p1 = product; end
          if (n_done == 2) begin second = i; p2 = product; end
        end
      end
      check("held_start_ops", 64'(n_done), 64'd2);
      check("held_start_first_done", 64'(first), 64'd9);
      check("held_start_spacing", 64'(second - first), 64'd10);
      check("held_start_p1", p1, 64'd4);
      check("held_start_p2", p2, 64'd4);
    end

    // reset dropped into the middle of RUN
    @(negedge clk);
    a = 32'd123456; b = -32'sd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_flags", {62'b0, busy, done}, 64'd0);
    check("midrun_reset_product", product, 64'd0);
    reset = 1'b0;
    run_op(32'd9, 32'd9, p, lat);
    check("after_reset_product", p, 64'd81);
    check("after_reset_latency", 64'(lat), 64'd9);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] ref_p;
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'd0;
      ref_p = $signed(ra) * $signed(rb);
      run_op(ra, rb, p, lat);
      check($sformatf("rand%0d_product", i), p, ref_p);
      if (lat != exp_lat(ra, rb))
        check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(ra, rb)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
